// File: rtl/conditional_subtractor_pkg.sv
// Shared types and sizing helpers for the word-serial conditional subtractor.
package conditional_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DECIDE,
    EMIT
  } state_t;

  function automatic int calc_num_words(input int bits_in_num, input int register_size);
    return bits_in_num / register_size;
  endfunction

endpackage

// File: rtl/word_buffer.sv
// Simple dual-port word store: one write port, one registered read port (1-cycle latency).
module word_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array and its read register carry no reset so the store maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/conditional_subtractor.sv
// Final reduction stage: fetches X and M word by word, forms X-M with a borrow chain,
// then bursts out X-M when X >= M, otherwise X unchanged.
module conditional_subtractor
  import conditional_subtractor_pkg::*;
#(
  parameter int BITS_IN_NUM   = 4096,
  parameter int REGISTER_SIZE = 32
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     start_in,
  input  logic [REGISTER_SIZE-1:0] data_in,
  input  logic [REGISTER_SIZE-1:0] modulus_in,
  input  logic                     data_valid_in,
  output logic                     consumed_out,
  output logic [REGISTER_SIZE-1:0] data_out,
  output logic                     data_valid_out,
  output logic                     reduced_out
);

  localparam int NUM_WORDS = calc_num_words(BITS_IN_NUM, REGISTER_SIZE);
  localparam int AW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int CW        = $clog2(NUM_WORDS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);
  localparam logic [CW-1:0] EMIT_END = CW'(NUM_WORDS);

  state_t                   state, state_next;
  logic [CW-1:0]            k;
  logic [CW-1:0]            emit_cnt;
  logic                     borrow;
  logic                     sel_diff;
  logic                     accept;
  logic                     req_next;
  logic                     emit_word;
  logic [REGISTER_SIZE:0]   diff;
  logic [AW-1:0]            wr_addr;
  logic [AW-1:0]            rd_addr;
  logic [REGISTER_SIZE-1:0] x_q;
  logic [REGISTER_SIZE-1:0] d_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_in) state_next = FETCH;
      FETCH:   if (data_valid_in && k == LAST_IDX) state_next = DECIDE;
      DECIDE:  state_next = EMIT;
      EMIT:    if (emit_cnt == EMIT_END) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: every signal written here gets a value on every path, so no latches are inferred.
  always_comb begin
    accept    = (state == FETCH) && data_valid_in;
    diff      = {1'b0, data_in} - {1'b0, modulus_in} - {{REGISTER_SIZE{1'b0}}, borrow};
    wr_addr   = k[AW-1:0];
    req_next  = ((state == IDLE) && start_in) || (accept && (k != LAST_IDX));
    emit_word = (state == EMIT) && (emit_cnt != EMIT_END);
    // Address 0 is issued in DECIDE so the read register holds word 0 when EMIT begins.
    rd_addr   = (state == DECIDE) ? '0 : AW'(emit_cnt + CW'(1));
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      k              <= '0;
      borrow         <= 1'b0;
      sel_diff       <= 1'b0;
      emit_cnt       <= '0;
      consumed_out   <= 1'b0;
      data_valid_out <= 1'b0;
      reduced_out    <= 1'b0;
      data_out       <= '0;
    end else begin
      consumed_out   <= req_next;
      data_valid_out <= emit_word;
      reduced_out    <= emit_word & sel_diff;
      data_out       <= emit_word ? (sel_diff ? d_q : x_q) : '0;

      if ((state == IDLE) && start_in) begin
        k      <= '0;
        borrow <= 1'b0;
      end else if (accept) begin
        k      <= k + CW'(1);
        borrow <= diff[REGISTER_SIZE];
      end

      // A clear final borrow means X >= M, so the difference is the reduced result.
      if (state == DECIDE) begin
        sel_diff <= !borrow;
        emit_cnt <= '0;
      end else if (emit_word) begin
        emit_cnt <= emit_cnt + CW'(1);
      end
    end
  end

  word_buffer #(
    .DEPTH (NUM_WORDS),
    .WIDTH (REGISTER_SIZE),
    .AW    (AW)
  ) x_buf (
    .clk     (clk_in),
    .wr_en   (accept),
    .wr_addr (wr_addr),
    .wr_data (data_in),
    .rd_addr (rd_addr),
    .rd_data (x_q)
  );

  word_buffer #(
    .DEPTH (NUM_WORDS),
    .WIDTH (REGISTER_SIZE),
    .AW    (AW)
  ) d_buf (
    .clk     (clk_in),
    .wr_en   (accept),
    .wr_addr (wr_addr),
    .wr_data (diff[REGISTER_SIZE-1:0]),
    .rd_addr (rd_addr),
    .rd_data (d_q)
  );

endmodule

// File: doc/conditional_subtractor.md
# conditional_subtractor

Word-serial final-reduction stage: pulls an N-bit number X one word at a time from an upstream word-replay buffer, subtracts a word-aligned modulus stream M with a borrow chain, and then emits either X−M (if X ≥ M) or X unchanged as a contiguous burst of words. It sits directly downstream of the replay buffer, driving that buffer's consumed/request input. Its output burst has the same format that buffer accepts on its write side (NUM_WORDS back-to-back valid words, LSW first), so stages can be chained.

## Interface
Parameters:
- BITS_IN_NUM, 4096, operand width in bits
- REGISTER_SIZE, 32, word width; BITS_IN_NUM must be a multiple of it
- derived NUM_WORDS = BITS_IN_NUM/REGISTER_SIZE (localparam)

Ports:
- clk_in  input  1  sole clock
- rst_n_in  input  1  reset, asynchronous, active-low
- start_in  input  1  one-cycle pulse; begin a new operand; honoured only in IDLE
- data_in  input  REGISTER_SIZE  word of X, LSW first
- modulus_in  input  REGISTER_SIZE  matching word of M, sampled with data_in
- data_valid_in  input  1  data_in/modulus_in valid this cycle
- consumed_out  output  1  one-cycle request pulse to upstream for the next word
- data_out  output  REGISTER_SIZE  result word, LSW first
- data_valid_out  output  1  data_out valid
- reduced_out  output  1  high during burst iff subtraction applied

## Operation
- States: IDLE → FETCH → DECIDE → EMIT → IDLE.
- IDLE: start_in → FETCH, word index k=0, borrow=0, one consumed_out pulse next cycle.
- FETCH: on data_valid_in, compute d = data_in − modulus_in − borrow in REGISTER_SIZE+1 bits; store data_in in x_buf[k] and d[REGISTER_SIZE-1:0] in d_buf[k]; borrow ← d[REGISTER_SIZE]; k++. If k < NUM_WORDS−1 before the increment, pulse consumed_out next cycle. The last word raises no pulse (total pulses per operand = NUM_WORDS, including the start pulse). Upstream response latency is arbitrary (≥1 cycle). The block waits indefinitely.
- DECIDE (1 cycle): sel ← (borrow==0) → d_buf, else x_buf; reduced_out ← !borrow.
- EMIT: read selected buffer at addresses 0..NUM_WORDS−1, one per cycle, no stalls.
- Ignored inputs: data_valid_in outside FETCH; start_in outside IDLE.
- X == M → all-zero result, reduced_out=1. X < M → X returned, reduced_out=0.
- Reset (async assert, any state): state=IDLE, k=0, borrow=0, consumed_out=0, data_valid_out=0, reduced_out=0, data_out=0. Buffer contents are don't-care.

## Timing
- start_in at cycle S → consumed_out high at S+1.
- Word accepted at cycle T (not last) → consumed_out high at T+1, exactly one cycle.
- Last word accepted at T → DECIDE at T+1, first read at T+2, data_valid_out high T+3..T+2+NUM_WORDS inclusive; reduced_out valid over the same window, 0 otherwise.
- IDLE re-entered the cycle after the last output word; the next start_in is honoured from then on.
- All outputs registered.

## Structure
- Package conditional_subtractor_pkg: state enum (IDLE, FETCH, DECIDE, EMIT) and a function returning NUM_WORDS from BITS_IN_NUM and REGISTER_SIZE.
- Sub-module word_buffer: NUM_WORDS×REGISTER_SIZE simple dual-port RAM, one write port, one registered read port (1-cycle latency), inferable as BRAM. Instantiated twice (x_buf, d_buf).
- Borrow arithmetic and FSM stay in the top module.

## Test plan
Parameters for all tests: BITS_IN_NUM=128, REGISTER_SIZE=32, NUM_WORDS=4. Words are listed LSW first. The bench models upstream with 3-cycle request-to-valid latency.
- X=[5,0,0,0], M=[7,0,0,0] → out [5,0,0,0], reduced_out=0, exactly 4 consumed_out pulses.
- X=M=[0xDEADBEEF,1,2,3] → out [0,0,0,0], reduced_out=1.
- X=[0,0,0,1], M=[1,0,0,0] → out [0xFFFFFFFF,0xFFFFFFFF,0xFFFFFFFF,0], reduced_out=1 (full borrow ripple).
- Timing: last word accepted at cycle T → data_valid_out exactly T+3..T+6. start_in during FETCH/EMIT and stray data_valid_in during EMIT → no change to result or pulse count.
- rst_n_in low after 2 words accepted → all outputs 0 immediately. A fresh operand then produces the correct result with no residue from the aborted one.
- Two operands back-to-back (start_in the cycle after the burst ends) → both results correct; the second operand's start pulse appears at S+1.
